dda_step_sequencer: RTL and testbench

Sequencer for the damped spring-mass DDA: runs a programmable number of explicit-Euler steps of dv1/dt = v2, dv2/dt = −(k/m)·v1 − (d/m)·v2. It time-shares one external 7.20 signed multiplier between the k/m and d/m products, so the block needs one multiplier instead of two. It owns the two state variables and exposes start/stop/done control to the top level.

---
 rtl/dda_step_sequencer.sv | 90 +++++++++
 tb/tb_dda_step_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dda_step_sequencer.sv
// dda_step_sequencer: explicit-Euler damped spring-mass stepper time-sharing one external multiplier
module dda_step_sequencer #(
  parameter int W = 27,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] n_steps,
  input  logic [3:0]        dt_shift,
  input  logic [W-1:0]      ic1,
  input  logic [W-1:0]      ic2,
  input  logic [W-1:0]      k_m,
  input  logic [W-1:0]      d_m,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_p,
  output logic [W-1:0]      v1,
  output logic [W-1:0]      v2,
  output logic [STEP_W-1:0] steps_done,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, MUL_K, MUL_D, UPDATE, DONE} state_t;
  state_t state;
  logic [W-1:0] p_k, p_d, k_r, d_r, f2;
  logic [STEP_W-1:0] n_r;
  logic [3:0] dt_r;
  logic stop_pend, last;
  assign f2 = -p_k - p_d;
  assign last = (steps_done + STEP_W'(1)) == n_r || stop_pend || stop;
  assign busy = state != IDLE;
  assign mul_a = state == MUL_K ? v1 : state == MUL_D ? v2 : '0;
  assign mul_b = state == MUL_K ? k_r : state == MUL_D ? d_r : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      v1 <= '0;
      v2 <= '0;
      p_k <= '0;
      p_d <= '0;
      k_r <= '0;
      d_r <= '0;
      n_r <= '0;
      dt_r <= '0;
      steps_done <= '0;
      stop_pend <= 1'b0;
      sample_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            n_r <= n_steps;
            dt_r <= dt_shift;
            k_r <= k_m;
            d_r <= d_m;
            v1 <= ic1;
            v2 <= ic2;
            steps_done <= '0;
            stop_pend <= 1'b0;
            state <= n_steps == '0 ? DONE : MUL_K;
            done <= n_steps == '0;
          end
        MUL_K: begin
          p_k <= mul_p;
          stop_pend <= stop_pend | stop;
          state <= MUL_D;
        end
        MUL_D: begin
          p_d <= mul_p;
          stop_pend <= stop_pend | stop;
          state <= UPDATE;
        end
        UPDATE: begin
          v1 <= v1 + W'($signed(v2) >>> dt_r);
          v2 <= v2 + W'($signed(f2) >>> dt_r);
          steps_done <= steps_done + STEP_W'(1);
          sample_valid <= 1'b1;
          state <= last ? DONE : MUL_K;
          done <= last;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dda_step_sequencer.sv
// tb_dda_step_sequencer: table-driven runs against a bit-exact Euler model plus reset/operand sequences
module tb_dda_step_sequencer;
  localparam int W = 27;
  localparam int SW = 16;
  logic clk = 1'b0;
  logic rst, start, stop;
  logic [SW-1:0] n_steps, steps_done;
  logic [3:0] dt_shift;
  logic [W-1:0] ic1, ic2, k_m, d_m, mul_a, mul_b, mul_p, v1, v2;
  logic sample_valid, busy, done;
  logic signed [2*W-1:0] prod;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [W-1:0] ic1, ic2, k, d;
    logic [3:0] dt;
    logic [SW-1:0] n;
    logic [W-1:0] e1, e2;
    logic [SW-1:0] es;
    bit hand;
    int stop_c, bs_c;
  } vec_t;
  vec_t tv[8];
  dda_step_sequencer #(.W(W), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .n_steps(n_steps),
    .dt_shift(dt_shift), .ic1(ic1), .ic2(ic2), .k_m(k_m), .d_m(d_m),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .v1(v1), .v2(v2),
    .steps_done(steps_done), .sample_valid(sample_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign prod = $signed(mul_a) * $signed(mul_b);
  assign mul_p = prod[W+19:20];
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [W-1:0] mulf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W+19:20];
  endfunction
  task automatic mstep(inout logic [W-1:0] a, inout logic [W-1:0] b,
                       input logic [W-1:0] k, input logic [W-1:0] d, input logic [3:0] dt);
    logic [W-1:0] f, na;
    logic signed [W-1:0] sb, sf;
    f = -mulf(a, k) - mulf(b, d);
    sb = b;
    sf = f;
    na = a + W'(sb >>> dt);
    b = b + W'(sf >>> dt);
    a = na;
  endtask
  task automatic run(input vec_t t, input int idx);
    logic [W-1:0] m1, m2;
    int pulses, c, lim;
    bit seen;
    m1 = t.ic1;
    m2 = t.ic2;
    pulses = 0;
    seen = 0;
    c = 0;
    lim = 3 * int'(t.n) + 20;
    @(negedge clk);
    ic1 = t.ic1; ic2 = t.ic2; k_m = t.k; d_m = t.d; dt_shift = t.dt; n_steps = t.n;
    start = 1'b1;
    while (!seen && c < lim) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      ic1 = t.ic1; ic2 = t.ic2; k_m = t.k; d_m = t.d; n_steps = t.n;
      if (idx == 0 && c == 1) begin
        chk("mulk_a", mul_a, 27'h0000000);
        chk("mulk_b", mul_b, 27'h0080000);
      end
      if (idx == 0 && c == 2) begin
        chk("muld_a", mul_a, 27'h0100000);
        chk("muld_b", mul_b, 27'h0040000);
      end
      if (idx == 0 && c == 3) chk("upd_a", mul_a, 27'h0000000);
      if (sample_valid) begin
        pulses++;
        mstep(m1, m2, t.k, t.d, t.dt);
        chk($sformatf("v%0d_sv_cycle", idx), W'(c), W'(3 * pulses + 1));
        chk($sformatf("v%0d_v1_p%0d", idx, pulses), v1, m1);
        chk($sformatf("v%0d_v2_p%0d", idx, pulses), v2, m2);
      end
      if (done) begin
        seen = 1;
        chk($sformatf("v%0d_done_cycle", idx), W'(c), W'(3 * int'(t.es) + 1));
        chk($sformatf("v%0d_steps", idx), W'(steps_done), W'(t.es));
        chk($sformatf("v%0d_pulses", idx), W'(pulses), W'(t.es));
        chk($sformatf("v%0d_busy_done", idx), W'(busy), W'(1));
        chk($sformatf("v%0d_sv_at_done", idx), W'(sample_valid), W'(t.es != 0));
        chk($sformatf("v%0d_v1_end", idx), v1, m1);
        chk($sformatf("v%0d_v2_end", idx), v2, m2);
        if (t.hand) begin
          chk($sformatf("v%0d_v1_hand", idx), v1, t.e1);
          chk($sformatf("v%0d_v2_hand", idx), v2, t.e2);
        end
      end
      stop = c == t.stop_c;
      if (c == t.bs_c) begin
        start = 1'b1;
        ic1 = ~t.ic1; ic2 = 27'h0000123; k_m = '0; d_m = '0; n_steps = 16'd3;
      end
    end
    stop = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d_timeout: got no done expected done within %0d cycles", idx, lim);
    end
  endtask
  initial begin
    tv[0] = '{27'h0000000, 27'h0100000, 27'h0080000, 27'h0040000, 4'd9, 16'd1,
              27'h0000800, 27'h00FFE00, 16'd1, 1'b1, 0, 0};
    tv[1] = '{27'h0000123, 27'h0000456, 27'h0080000, 27'h0040000, 4'd3, 16'd0,
              27'h0000123, 27'h0000456, 16'd0, 1'b1, 0, 0};
    tv[2] = '{27'h3FFFFFF, 27'h3FFFFFF, 27'h0000000, 27'h0000000, 4'd0, 16'd1,
              27'h7FFFFFE, 27'h3FFFFFF, 16'd1, 1'b1, 0, 0};
    tv[3] = '{27'h4000000, 27'h0000000, 27'h0100000, 27'h0000000, 4'd0, 16'd1,
              27'h4000000, 27'h4000000, 16'd1, 1'b1, 0, 0};
    tv[4] = '{27'h0100000, 27'h0000000, 27'h0100000, 27'h0000000, 4'd1, 16'd2,
              27'h00C0000, 27'h7F00000, 16'd2, 1'b1, 0, 0};
    tv[5] = '{27'h0000000, 27'h0100000, 27'h0080000, 27'h0040000, 4'd9, 16'd1000,
              27'h0, 27'h0, 16'd1000, 1'b0, 0, 0};
    tv[6] = '{27'h0000000, 27'h0100000, 27'h0080000, 27'h0040000, 4'd4, 16'd10,
              27'h0, 27'h0, 16'd10, 1'b0, 0, 5};
    tv[7] = '{27'h0000000, 27'h0100000, 27'h0080000, 27'h0040000, 4'd9, 16'd100,
              27'h0, 27'h0, 16'd5, 1'b0, 14, 0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; n_steps = '0; dt_shift = '0;
    ic1 = '0; ic2 = '0; k_m = '0; d_m = '0;
    repeat (2) @(negedge clk);
    chk("por_v1", v1, '0);
    chk("por_v2", v2, '0);
    chk("por_steps", W'(steps_done), '0);
    chk("por_busy", W'(busy), '0);
    chk("por_done", W'(done), '0);
    chk("por_sv", W'(sample_valid), '0);
    chk("por_mul_a", mul_a, '0);
    chk("por_mul_b", mul_b, '0);
    rst = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", W'(busy), '0);
    for (int i = 0; i < 8; i++) run(tv[i], i);
    @(negedge clk);
    ic1 = 27'h0000000; ic2 = 27'h0100000; k_m = 27'h0080000; d_m = 27'h0040000;
    dt_shift = 4'd9; n_steps = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid_busy", W'(busy), W'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_v1", v1, '0);
    chk("mid_v2", v2, '0);
    chk("mid_steps", W'(steps_done), '0);
    chk("mid_busy_rst", W'(busy), '0);
    chk("mid_done", W'(done), '0);
    chk("mid_sv", W'(sample_valid), '0);
    chk("mid_mul_a", mul_a, '0);
    chk("mid_mul_b", mul_b, '0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", W'(busy), '0);
    chk("post_rst_v1", v1, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
